// File: rtl/subtractor_pkg.sv
// -----------------------------------------------------------------------------
// subtractor_pkg
// Shared definitions for the chunk-serial subtractor:
//   state_t     - controller states (IDLE, BUSY, DONE)
//   num_chunks  - number of CHUNK-bit slices in a WIDTH-bit operand
//   cnt_width   - width of the slice counter, never narrower than one bit
// -----------------------------------------------------------------------------
package subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int num_chunks(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-slice configuration still needs a one-bit counter so the
    // counter type stays legal.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/subtract_slice.sv
// -----------------------------------------------------------------------------
// subtract_slice
// Combinational CHUNK-bit subtract with borrow: {borrow_out, diff} = a - b - borrow_in.
// Ports:
//   a, b        CHUNK-bit operand slices
//   borrow_in   borrow from the next-lower slice
//   diff        CHUNK-bit slice difference
//   borrow_out  borrow into the next-higher slice
// -----------------------------------------------------------------------------
module subtract_slice #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             borrow_in,
    output logic [CHUNK-1:0] diff,
    output logic             borrow_out
);

    // One extra bit on top: the result lies in [-2^CHUNK, 2^CHUNK-1], so the
    // top bit of the (CHUNK+1)-bit difference is set exactly when it is negative.
    logic [CHUNK:0] wide;

    assign wide       = {1'b0, a} - {1'b0, b} - {{CHUNK{1'b0}}, borrow_in};
    assign diff       = wide[CHUNK-1:0];
    assign borrow_out = wide[CHUNK];

endmodule

// File: rtl/multi_cycle_subtractor.sv
// -----------------------------------------------------------------------------
// multi_cycle_subtractor
// Chunk-serial subtractor: D = A - B - B_in (mod 2^WIDTH), one CHUNK-bit slice
// per clock, LSB slice first, borrow held in a register between slices.
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready   operand handshake (A, B, B_in captured on accept)
//   out_valid / out_ready result handshake (D, B_out, V valid in DONE)
//   D                     difference
//   B_out                 final borrow (unsigned A < B + B_in)
//   V                     two's-complement overflow of the subtraction
// -----------------------------------------------------------------------------
module multi_cycle_subtractor
    import subtractor_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             B_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             B_out,
    output logic             V
);

    localparam int NUM_CHUNKS = num_chunks(WIDTH, CHUNK);
    localparam int CNT_W      = cnt_width(NUM_CHUNKS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0] cnt;
    logic             borrow;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] d_reg;
    logic             b_out_reg;
    logic             v_reg;

    logic [CHUNK-1:0] a_slice;
    logic [CHUNK-1:0] b_slice;
    logic [CHUNK-1:0] diff;
    logic             slice_borrow;
    logic             accept;
    logic             last_slice;

    // Select the operand slice addressed by the counter.
    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int k = 0; k < NUM_CHUNKS; k++) begin
            if (cnt == CNT_W'(k)) begin
                a_slice = a_reg[k*CHUNK +: CHUNK];
                b_slice = b_reg[k*CHUNK +: CHUNK];
            end
        end
    end

    subtract_slice #(
        .CHUNK (CHUNK)
    ) u_slice (
        .a          (a_slice),
        .b          (b_slice),
        .borrow_in  (borrow),
        .diff       (diff),
        .borrow_out (slice_borrow)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        last_slice = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (cnt == LAST_CNT) begin
                    last_slice = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture; contents are only meaningful after an accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_reg <= A;
            b_reg <= B;
        end
    end

    // Slice sequencing, borrow chain and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            borrow    <= 1'b0;
            d_reg     <= '0;
            b_out_reg <= 1'b0;
            v_reg     <= 1'b0;
        end else if (accept) begin
            cnt    <= '0;
            borrow <= B_in;
        end else if (state == BUSY) begin
            for (int k = 0; k < NUM_CHUNKS; k++) begin
                if (cnt == CNT_W'(k)) begin
                    d_reg[k*CHUNK +: CHUNK] <= diff;
                end
            end
            borrow <= slice_borrow;
            cnt    <= last_slice ? '0 : cnt + CNT_W'(1);
            if (last_slice) begin
                // The top slice's diff MSB is the result sign bit.
                b_out_reg <= slice_borrow;
                v_reg     <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                             (diff[CHUNK-1] != a_reg[WIDTH-1]);
            end
        end
    end

    assign D     = d_reg;
    assign B_out = b_out_reg;
    assign V     = v_reg;

endmodule

// File: tb/tb_multi_cycle_subtractor.sv
// -----------------------------------------------------------------------------
// tb_multi_cycle_subtractor
// Scoreboard bench: the driver pushes the reference result of each accepted
// operation; a monitor pops and compares when the DUT hands out a result.
// A second instance with CHUNK = WIDTH covers the single-slice configuration.
// -----------------------------------------------------------------------------
module tb_multi_cycle_subtractor;

    localparam int WIDTH      = 32;
    localparam int CHUNK      = 8;
    localparam int NUM_CHUNKS = WIDTH / CHUNK;

    typedef struct {
        logic [31:0] d;
        logic        bo;
        logic        v;
        int          acc;
    } sb_entry_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        B_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] D;
    logic        B_out;
    logic        V;

    logic        in_valid2;
    logic        in_ready2;
    logic [31:0] A2;
    logic [31:0] B2;
    logic        B_in2;
    logic        out_valid2;
    logic        out_ready2;
    logic [31:0] D2;
    logic        B_out2;
    logic        V2;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          rdy_mode = 0;
    sb_entry_t   sb[$];

    multi_cycle_subtractor #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .B_in(B_in), .out_valid(out_valid), .out_ready(out_ready),
        .D(D), .B_out(B_out), .V(V)
    );

    multi_cycle_subtractor #(.WIDTH(32), .CHUNK(32)) dut_wide (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .A(A2), .B(B2), .B_in(B_in2), .out_valid(out_valid2), .out_ready(out_ready2),
        .D(D2), .B_out(B_out2), .V(V2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain WIDTH-bit modular and signed arithmetic.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic bin,
                                  output logic [31:0] d, output logic bo, output logic v);
        longint r;
        d  = a - b - {31'b0, bin};
        bo = ({1'b0, a} < ({1'b0, b} + {32'b0, bin}));
        r  = longint'($signed(a)) - longint'($signed(b)) - longint'({63'b0, bin});
        v  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // out_ready driver: 0 = held high, 1 = random, 2 = held low
    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor
    sb_entry_t   mon_e;
    bit          hold;
    bit          prev_valid;
    logic [31:0] hd;
    logic        hbo;
    logic        hv;

    always @(negedge clk) begin
        if (rst) begin
            hold       = 0;
            prev_valid = 0;
        end else begin
            if (hold) begin
                check("hold_out_valid", 64'(out_valid), 64'd1);
                check("hold_D", 64'(D), 64'(hd));
                check("hold_B_out", 64'(B_out), 64'(hbo));
                check("hold_V", 64'(V), 64'(hv));
            end
            if (out_valid && !prev_valid) begin
                check("output_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    check("latency", 64'(cyc - sb[0].acc), 64'(NUM_CHUNKS));
                end
            end
            if (out_valid) begin
                check("in_ready_low_in_done", 64'(in_ready), 64'd0);
            end
            if (out_valid && out_ready && sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("result_D", 64'(D), 64'(mon_e.d));
                check("result_B_out", 64'(B_out), 64'(mon_e.bo));
                check("result_V", 64'(V), 64'(mon_e.v));
            end
            hold       = out_valid && !out_ready;
            hd         = D;
            hbo        = B_out;
            hv         = V;
            prev_valid = out_valid;
        end
    end

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic bin);
        sb_entry_t e;
        bit ok;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        check("in_ready_wait", 64'(ok), 64'd1);
        if (!ok) return;
        A = a; B = b; B_in = bin; in_valid = 1'b1;
        @(posedge clk);
        #1;
        model(a, b, bin, e.d, e.bo, e.v);
        e.acc = cyc;
        sb.push_back(e);
        // Keep in_valid high with junk operands for one busy cycle.
        A = $urandom; B = $urandom; B_in = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && in_ready) begin
                ok = 1;
                break;
            end
        end
        check("drain", 64'(ok), 64'd1);
    endtask

    task automatic do_op2(input logic [31:0] a, input logic [31:0] b, input logic bin);
        logic [31:0] ed;
        logic        ebo;
        logic        ev;
        model(a, b, bin, ed, ebo, ev);
        @(negedge clk);
        check("wide_in_ready", 64'(in_ready2), 64'd1);
        A2 = a; B2 = b; B_in2 = bin; in_valid2 = 1'b1;
        @(posedge clk);
        #1;
        in_valid2 = 1'b0;
        check("wide_busy_no_valid", 64'(out_valid2), 64'd0);
        @(posedge clk);
        #1;
        check("wide_valid", 64'(out_valid2), 64'd1);
        check("wide_D", 64'(D2), 64'(ed));
        check("wide_B_out", 64'(B_out2), 64'(ebo));
        check("wide_V", 64'(V2), 64'(ev));
        @(posedge clk);
        #1;
        check("wide_back_idle", 64'(in_ready2), 64'd1);
    endtask

    initial begin
        bit          ok;
        logic [31:0] sd;
        logic        sbo;
        logic        sv;

        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; B_in = 1'b0; out_ready = 1'b1;
        in_valid2 = 1'b0; A2 = '0; B2 = '0; B_in2 = 1'b0; out_ready2 = 1'b1;
        rdy_mode = 0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_D", 64'(D), 64'd0);
        check("reset_B_out", 64'(B_out), 64'd0);
        check("reset_V", 64'(V), 64'd0);
        check("reset_wide_in_ready", 64'(in_ready2), 64'd1);
        check("reset_wide_out_valid", 64'(out_valid2), 64'd0);
        #2;
        rst = 1'b0;

        // Directed operations, out_ready held high
        do_op(32'h0000_0005, 32'h0000_0003, 1'b0);
        do_op(32'h0000_0000, 32'h0000_0001, 1'b0);
        do_op(32'h8000_0000, 32'h0000_0001, 1'b0);
        do_op(32'h0000_000A, 32'h0000_0003, 1'b1);
        do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        drain();

        // Backpressure: result held for 5 cycles, then released
        rdy_mode  = 2;
        out_ready = 1'b0;
        do_op(32'h0001_0000, 32'h0000_0001, 1'b1);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1;
                break;
            end
        end
        check("bp_out_valid_wait", 64'(ok), 64'd1);
        sd = D; sbo = B_out; sv = V;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_D_stable", 64'(D), 64'(sd));
            check("bp_B_out_stable", 64'(B_out), 64'(sbo));
            check("bp_V_stable", 64'(V), 64'(sv));
        end
        @(posedge clk);
        #2;
        rdy_mode  = 0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_out_valid", 64'(out_valid), 64'd0);
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        drain();

        // Reset on the second busy cycle aborts the operation
        do_op(32'h1234_5678, 32'h0000_1111, 1'b0);
        rst = 1'b1;
        #1;
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_D", 64'(D), 64'd0);
        check("abort_B_out", 64'(B_out), 64'd0);
        sb.delete();
        @(posedge clk);
        #3;
        rst = 1'b0;
        for (int i = 0; i < NUM_CHUNKS + 3; i++) begin
            @(negedge clk);
            check("abort_no_result", 64'(out_valid), 64'd0);
        end
        do_op(32'h0000_0100, 32'h0000_0001, 1'b1);
        drain();

        // Randomized operations with random backpressure and gaps
        rdy_mode = 1;
        for (int n = 0; n < 60; n++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            do_op(pick(), pick(), 1'($urandom_range(0, 1)));
        end
        drain();
        rdy_mode = 0;

        // Single-slice configuration
        do_op2(32'h1234_5678, 32'h0000_0078, 1'b0);
        do_op2(32'h0000_0000, 32'h0000_0001, 1'b0);
        do_op2(32'h8000_0000, 32'h0000_0001, 1'b0);
        for (int n = 0; n < 10; n++) begin
            do_op2(pick(), pick(), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
